// File: rtl/grid_io_pkg.sv
// Shared constants for the I/O grid tile: per-pad config word layout and defaults.
package grid_io_pkg;

  // Bit positions inside one pad's configuration word
  localparam int CFG_OE      = 0;
  localparam int CFG_INV_OUT = 1;
  localparam int CFG_INV_IN  = 2;

  // Default width of one pad's configuration word
  localparam int DEFAULT_CFG_BITS = 3;

  // Default number of pads in a tile
  localparam int DEFAULT_NUM_IO = 8;

endpackage

// File: rtl/io_pad_cell.sv
// One general-purpose pad: optional output drive with inversion, and an
// always-on input path with its own inversion so loopback is observable.
module io_pad_cell
  import grid_io_pkg::*;
#(
  parameter int CFG_BITS = DEFAULT_CFG_BITS
) (
  input  logic [CFG_BITS-1:0] cfg,
  input  logic                outpad,
  inout  wire                 pad,
  output logic                inpad
);

  logic drive_val;

  assign drive_val = outpad ^ cfg[CFG_INV_OUT];

  // Tri-state the pad unless the output enable bit is set
  assign pad = cfg[CFG_OE] ? drive_val : 1'bz;

  // The input path reads the pad itself, so it also sees our own drive
  assign inpad = pad ^ cfg[CFG_INV_IN];

endmodule

// File: rtl/grid_io_cfg_tile.sv
// Perimeter I/O tile: a counted configuration chain feeds a shadow register
// that is committed atomically; the shadow alone controls the pads.
module grid_io_cfg_tile
  import grid_io_pkg::*;
#(
  parameter  int NUM_IO   = DEFAULT_NUM_IO,
  parameter  int CFG_BITS = DEFAULT_CFG_BITS,
  localparam int L        = NUM_IO * CFG_BITS,
  localparam int CW       = $clog2(L + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_en,
  input  logic              ccff_head,
  input  logic              ccff_load,
  input  logic [NUM_IO-1:0] top_pin_outpad,
  inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_PAD,
  output logic [NUM_IO-1:0] top_pin_inpad,
  output logic              ccff_tail,
  output logic              ccff_done,
  output logic              cfg_err,
  output logic [CW-1:0]     cfg_count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(L);

  logic [L-1:0]  sr;
  logic [L-1:0]  shadow;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          commit_ok;

  assign ccff_done = (cnt == FULL_COUNT);
  assign commit_ok = ccff_load && ccff_done;
  assign ccff_tail = sr[L-1];
  assign cfg_count = cnt;
  assign cfg_err   = err_q;

  // Configuration chain: newest bit enters at sr[0], oldest leaves at the tail
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sr <= '0;
    end else if (ccff_en) begin
      sr <= {sr[L-2:0], ccff_head};
    end
  end

  // Bit counter: restarts on a good commit (counting a same-cycle shift), else saturates at L
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      cnt <= '0;
    end else if (commit_ok) begin
      cnt <= ccff_en ? CW'(1) : '0;
    end else if (ccff_en && !ccff_done) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow register captures the whole chain at once so pads never see a partial config
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow <= '0;
    end else if (commit_ok) begin
      shadow <= sr;
    end
  end

  // Sticky error: a commit asked for before the chain was full is remembered until reset
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      err_q <= 1'b0;
    end else if (ccff_load && !ccff_done) begin
      err_q <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_IO; p++) begin : g_pad
    io_pad_cell #(
      .CFG_BITS (CFG_BITS)
    ) u_pad (
      .cfg    (shadow[p*CFG_BITS +: CFG_BITS]),
      .outpad (top_pin_outpad[p]),
      .pad    (gfpga_pad_GPIO_PAD[p]),
      .inpad  (top_pin_inpad[p])
    );
  end

endmodule

// File: tb/tb_grid_io_cfg_tile.sv
// Self-checking bench for grid_io_cfg_tile: directed scenarios plus random
// traffic, compared every cycle against a history-based behavioural model.
module tb_grid_io_cfg_tile;

  localparam int NUM_IO   = 8;
  localparam int CFG_BITS = 3;
  localparam int L        = NUM_IO * CFG_BITS;
  localparam int CW       = $clog2(L + 1);

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              ccff_en;
  logic              ccff_head;
  logic              ccff_load;
  logic [NUM_IO-1:0] top_pin_outpad;
  logic [NUM_IO-1:0] top_pin_inpad;
  wire  [NUM_IO-1:0] gpio;
  logic              ccff_tail;
  logic              ccff_done;
  logic              cfg_err;
  logic [CW-1:0]     cfg_count;

  logic [NUM_IO-1:0] ext_req;
  logic [NUM_IO-1:0] ext_en;
  logic [NUM_IO-1:0] ext_val;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Model: every bit ever shifted (newest last), committed pad words, count, error
  bit       hist[$];
  bit [2:0] m_cfg[NUM_IO];
  int       m_cnt;
  bit       m_err;

  // Free-running programming clock
  always #5 prog_clk = ~prog_clk;

  for (genvar i = 0; i < NUM_IO; i++) begin : g_ext
    assign gpio[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  grid_io_cfg_tile #(
    .NUM_IO   (NUM_IO),
    .CFG_BITS (CFG_BITS)
  ) dut (
    .prog_clk           (prog_clk),
    .pReset             (pReset),
    .ccff_en            (ccff_en),
    .ccff_head          (ccff_head),
    .ccff_load          (ccff_load),
    .top_pin_outpad     (top_pin_outpad),
    .gfpga_pad_GPIO_PAD (gpio),
    .top_pin_inpad      (top_pin_inpad),
    .ccff_tail          (ccff_tail),
    .ccff_done          (ccff_done),
    .cfg_err            (cfg_err),
    .cfg_count          (cfg_count)
  );

  // Chain position k holds the bit shifted in k shifts ago (0 if never shifted)
  function automatic bit chain_bit(int k);
    if (hist.size() > k) return hist[hist.size() - 1 - k];
    return 1'b0;
  endfunction

  function automatic logic [NUM_IO-1:0] model_oe();
    logic [NUM_IO-1:0] r;
    for (int p = 0; p < NUM_IO; p++) r[p] = m_cfg[p][0];
    return r;
  endfunction

  task automatic compare(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    bit full;
    if (pReset) begin
      hist.delete();
      for (int p = 0; p < NUM_IO; p++) m_cfg[p] = '0;
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      full = (m_cnt == L);
      if (ccff_load) begin
        if (full) begin
          for (int p = 0; p < NUM_IO; p++)
            for (int b = 0; b < CFG_BITS; b++)
              m_cfg[p][b] = chain_bit(p * CFG_BITS + b);
          m_cnt = 0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (ccff_en) begin
        hist.push_back(ccff_head);
        while (hist.size() > 40) void'(hist.pop_front());
        if (m_cnt < L) m_cnt++;
      end
    end
  endtask

  task automatic checkOutput();
    bit exp_pad;
    compare("ccff_done", ccff_done, m_cnt == L);
    compare("cfg_count", cfg_count, m_cnt);
    compare("cfg_err", cfg_err, m_err);
    compare("ccff_tail", ccff_tail, chain_bit(L - 1));
    for (int p = 0; p < NUM_IO; p++) begin
      if (m_cfg[p][0]) begin
        exp_pad = top_pin_outpad[p] ^ m_cfg[p][1];
        compare($sformatf("pad%0d", p), gpio[p], exp_pad);
        compare($sformatf("inpad%0d", p), top_pin_inpad[p], exp_pad ^ m_cfg[p][2]);
      end else if (ext_en[p]) begin
        compare($sformatf("inpad%0d", p), top_pin_inpad[p], ext_val[p] ^ m_cfg[p][2]);
      end
    end
  endtask

  // Compare process: outputs are sampled mid-cycle, away from the active edge
  always @(negedge prog_clk) begin
    if (chk_on) checkOutput();
  end

  // One full clock cycle; external pad drive is withheld wherever the model says the DUT drives
  task automatic applyStimulus(input bit en, input bit head, input bit load, input bit rst);
    ccff_en   = en;
    ccff_head = head;
    ccff_load = load;
    pReset    = rst;
    ext_en    = ext_req & ~model_oe();
    @(posedge prog_clk);
    model_step();
    #1;
    ext_en = ext_req & ~model_oe();
    @(negedge prog_clk);
    #1;
  endtask

  task automatic shift_word(input logic [L-1:0] w);
    for (int b = L - 1; b >= 0; b--) applyStimulus(1'b1, w[b], 1'b0, 1'b0);
  endtask

  bit t4_bits[30];
  bit r_en, r_load, r_rst;

  initial begin
    for (int p = 0; p < NUM_IO; p++) m_cfg[p] = '0;
    m_cnt = 0;
    m_err = 1'b0;
    top_pin_outpad = '0;
    ext_req = '0;
    ext_val = '0;
    ext_en  = '0;

    // 1: reset and idle, pads float and inpad follows external drive
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    chk_on = 1'b1;
    compare("rst_count", cfg_count, 0);
    compare("rst_done", ccff_done, 0);
    compare("rst_err", cfg_err, 0);
    compare("rst_tail", ccff_tail, 0);
    ext_req = 8'hFF;
    ext_val = 8'h00;
    applyStimulus(0, 0, 0, 0);
    compare("t1_inpad0", top_pin_inpad, 8'h00);
    ext_val = 8'hFF;
    applyStimulus(0, 0, 0, 0);
    compare("t1_inpad1", top_pin_inpad, 8'hFF);

    // 2: pad3 = OE|INV_OUT, outpad[3]=1 drives 0
    ext_req = '0;
    applyStimulus(0, 0, 0, 1);
    top_pin_outpad = 8'h08;
    shift_word(24'h000600);
    compare("t2_full_count", cfg_count, 24);
    compare("t2_full_done", ccff_done, 1);
    applyStimulus(0, 0, 1, 0);
    compare("t2_pad3", gpio[3], 0);
    compare("t2_done_fall", ccff_done, 0);
    ext_req = 8'hF7;
    ext_val = 8'hA5;
    applyStimulus(0, 0, 0, 0);
    compare("t2_inpad", top_pin_inpad, 8'hA5);

    // 3: premature commit sets sticky error and leaves pads alone
    ext_req = '0;
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1'($urandom), 0, 0);
    applyStimulus(0, 0, 1, 0);
    compare("t3_err", cfg_err, 1);
    compare("t3_count", cfg_count, 10);
    shift_word(24'h000600);
    applyStimulus(0, 0, 1, 0);
    compare("t3_err_sticky", cfg_err, 1);
    compare("t3_pad3", gpio[3], 0);

    // 4: overshifting saturates the count and streams the oldest bits out
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      t4_bits[i] = 1'($urandom);
      applyStimulus(1, t4_bits[i], 0, 0);
      if (i >= 23 && i < 29) compare("t4_tail", ccff_tail, t4_bits[i - 23]);
    end
    compare("t4_count", cfg_count, 24);

    // 5: shift and commit together: shadow takes the pre-shift chain, count restarts at 1
    applyStimulus(1, 1, 1, 0);
    compare("t5_count", cfg_count, 1);
    compare("t5_done", ccff_done, 0);

    // 6: input inversion on pad2, then reset mid-shift
    applyStimulus(0, 0, 0, 1);
    shift_word(24'h000100);
    applyStimulus(0, 0, 1, 0);
    ext_req = 8'h04;
    ext_val = 8'h04;
    applyStimulus(0, 0, 0, 0);
    compare("t6_inpad2", top_pin_inpad[2], 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, 1'($urandom), 0, 0);
    compare("t6_mid_count", cfg_count, 12);
    applyStimulus(0, 0, 0, 1);
    compare("t6_rst_count", cfg_count, 0);
    ext_req = 8'hFF;
    ext_val = 8'h5A;
    applyStimulus(0, 0, 0, 0);
    compare("t6_rst_inpad", top_pin_inpad, 8'h5A);

    // Random traffic; a commit that cannot succeed is issued without a shift
    for (int c = 0; c < 3000; c++) begin
      r_load = ($urandom_range(0, 19) == 0);
      r_en   = ($urandom_range(0, 9) < 7);
      r_rst  = ($urandom_range(0, 399) == 0);
      if (r_load && m_cnt != L) r_en = 1'b0;
      top_pin_outpad = 8'($urandom);
      ext_req        = 8'($urandom);
      ext_val        = 8'($urandom);
      applyStimulus(r_en, 1'($urandom), r_load, r_rst);
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
